// File: rtl/xge_pkt_pkg.sv
// Shared types for the 10G packet receive path.
// Word bundle, widths and default frame limits.
package xge_pkt_pkg;

    localparam int MOD_W               = 3;
    localparam int BYTES_PER_WORD      = 8;
    localparam int DEF_MIN_FRAME_BYTES = 64;
    localparam int DEF_MAX_FRAME_BYTES = 1518;

    typedef struct packed {
        logic [63:0]      data;
        logic             sop;
        logic             eop;
        logic [MOD_W-1:0] mod;
        logic             err;
    } pkt_word_t;

    // Bytes carried by a word: full unless it is an eop with nonzero mod.
    function automatic logic [3:0] word_bytes(
        input logic             eop,
        input logic [MOD_W-1:0] mod
    );
        if (eop && (mod != '0)) begin
            return {1'b0, mod};
        end
        return 4'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/pkt_rx_reader_skid2.sv
// Two-entry FIFO of packet words.
// Entry 0 is always the head; unused entries are kept at zero.
module pkt_skid2
    import xge_pkt_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  pkt_word_t push_word,
    input  logic      pop,
    output pkt_word_t head,
    output logic [1:0] occ
);

    pkt_word_t  e0_q, e0_d;
    pkt_word_t  e1_q, e1_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push;
    logic       do_pop;

    // Next-state for the two entries and occupancy.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        occ_d   = occ_q;
        do_pop  = pop && (occ_q != 2'd0);
        do_push = push && ((occ_q != 2'd2) || do_pop);
        if (do_push && !do_pop) begin
            if (occ_q == 2'd0) begin
                e0_d = push_word;
            end else begin
                e1_d = push_word;
            end
            occ_d = occ_q + 2'd1;
        end else if (!do_push && do_pop) begin
            e0_d  = e1_q;
            e1_d  = '0;
            occ_d = occ_q - 2'd1;
        end else if (do_push && do_pop) begin
            if (occ_q == 2'd2) begin
                e0_d = e1_q;
                e1_d = push_word;
            end else begin
                e0_d = push_word;
            end
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/pkt_rx_reader.sv
// Reads queued frames from the MAC rx FIFO into a 2-deep buffer,
// checks frame length and framing, and keeps frame/error counters.
module pkt_rx_reader
    import xge_pkt_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
    parameter int MIN_FRAME_BYTES = DEF_MIN_FRAME_BYTES
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic        pkt_rx_val,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    output logic        out_err,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_cnt,
    output logic [15:0] last_len,
    output logic        frame_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

    logic [0:0]  state_q, state_d;
    logic        ren_prev_q;
    logic        in_frame_q, in_frame_d;
    logic        sop_err_q, sop_err_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] len_q, len_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [15:0] last_len_q, last_len_d;
    logic        frame_done_q, frame_done_d;

    pkt_word_t   head;
    pkt_word_t   push_word;
    logic [1:0]  occ;
    logic        pop;
    logic        accept;
    logic        abort;
    logic        val_eop;
    logic [2:0]  fill;
    logic [15:0] base;
    logic [16:0] sum;
    logic [15:0] len_new;
    logic        eop_err;
    logic [1:0]  err_inc;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign val_eop   = pkt_rx_val && pkt_rx_eop;

    // Read enable: only while reading, not on the eop arrival, and only
    // when the word it fetches is guaranteed a buffer slot.
    always_comb begin
        fill = {1'b0, occ} + {2'b0, ren_prev_q} - {2'b0, pop};
        pkt_rx_ren = (state_q == S_READ) && !val_eop && (fill < 3'd2);
    end

    // FSM; the eop arrival cycle doubles as the idle slot when the next
    // frame is already waiting.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (pkt_rx_avail) begin
                state_d = S_READ;
            end
        end else if (val_eop) begin
            state_d = pkt_rx_avail ? S_READ : S_IDLE;
        end
    end

    // Word acceptance, length tracking, error marking and counters.
    always_comb begin
        accept  = pkt_rx_val && (pkt_rx_sop || in_frame_q);
        abort   = pkt_rx_val && pkt_rx_sop && in_frame_q;
        base    = pkt_rx_sop ? 16'd0 : len_q;
        sum     = {1'b0, base} + {13'd0, word_bytes(pkt_rx_eop, pkt_rx_mod)};
        len_new = sum[16] ? 16'hFFFF : sum[15:0];
        eop_err = pkt_rx_err || (len_new < MIN_LEN) || (len_new > MAX_LEN)
                  || (pkt_rx_sop ? sop_err_q : frame_err_q);

        push_word.data = pkt_rx_data;
        push_word.sop  = pkt_rx_sop;
        push_word.eop  = pkt_rx_eop;
        push_word.mod  = pkt_rx_mod;
        push_word.err  = pkt_rx_eop && eop_err;

        in_frame_d   = in_frame_q;
        sop_err_d    = sop_err_q;
        frame_err_d  = frame_err_q;
        len_d        = len_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        last_len_d   = last_len_q;
        frame_done_d = 1'b0;
        err_inc      = {1'b0, abort} + {1'b0, pkt_rx_eop && eop_err};

        if (pkt_rx_val && !accept) begin
            sop_err_d = 1'b1;
        end
        if (accept) begin
            if (pkt_rx_sop) begin
                frame_err_d = sop_err_q;
                sop_err_d   = 1'b0;
            end
            err_cnt_d = err_cnt_q + {30'd0, err_inc};
            if (pkt_rx_eop) begin
                in_frame_d   = 1'b0;
                frame_err_d  = 1'b0;
                len_d        = 16'd0;
                frame_cnt_d  = frame_cnt_q + 32'd1;
                last_len_d   = len_new;
                frame_done_d = 1'b1;
            end else begin
                in_frame_d = 1'b1;
                len_d      = len_new;
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q      <= S_IDLE;
            ren_prev_q   <= 1'b0;
            in_frame_q   <= 1'b0;
            sop_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            len_q        <= 16'd0;
            frame_cnt_q  <= 32'd0;
            err_cnt_q    <= 32'd0;
            last_len_q   <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ren_prev_q   <= pkt_rx_ren;
            in_frame_q   <= in_frame_d;
            sop_err_q    <= sop_err_d;
            frame_err_q  <= frame_err_d;
            len_q        <= len_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            last_len_q   <= last_len_d;
            frame_done_q <= frame_done_d;
        end
    end

    pkt_skid2 u_buf (
        .clk       (clk_156m25),
        .rst       (reset_156m25),
        .push      (accept),
        .push_word (push_word),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign out_data   = head.data;
    assign out_sop    = head.sop;
    assign out_eop    = head.eop;
    assign out_mod    = head.mod;
    assign out_err    = head.err;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign last_len   = last_len_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Bench for pkt_rx_reader: MAC model, frame-level scoreboard,
// directed scenarios and randomized traffic.
module tb_pkt_rx_reader;
    import xge_pkt_pkg::*;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] e;
        logic [15:0] l;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        avail, ren, val, sop, eop, err;
    logic [63:0] data;
    logic [2:0]  mod;
    logic        out_valid, out_ready, out_sop, out_eop, out_err;
    logic [63:0] out_data;
    logic [2:0]  out_mod;
    logic [31:0] frame_cnt, err_cnt;
    logic [15:0] last_len;
    logic        frame_done;

    pkt_rx_reader dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .pkt_rx_avail (avail),
        .pkt_rx_ren   (ren),
        .pkt_rx_val   (val),
        .pkt_rx_data  (data),
        .pkt_rx_sop   (sop),
        .pkt_rx_eop   (eop),
        .pkt_rx_mod   (mod),
        .pkt_rx_err   (err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_mod      (out_mod),
        .out_err      (out_err),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .last_len     (last_len),
        .frame_done   (frame_done)
    );

    int vectors = 0;
    int miscompares = 0;

    pkt_word_t mac_q[$];
    pkt_word_t exp_q[$];
    snap_t     snap_q[$];
    int        exp_frames = 0;
    int        exp_errs = 0;
    bit        pend_sop_err = 0;
    bit        inject = 0;
    bit        rand_ready = 0;
    bit        force_ready = 1;
    bit        meas = 0;
    int        cyc = 0;
    int        ren_cnt = 0, ren_first = 0, ren_last = 0;
    int        out_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Frame of n bytes: MAC-side words plus the words and counter
    // values the reader must present for it.
    task automatic add_frame(input int n, input bit merr);
        int nw;
        bit ferr;
        pkt_word_t w;
        nw = (n + 7) / 8;
        ferr = merr || (n < 64) || (n > 1518) || pend_sop_err;
        for (int k = 0; k < nw; k++) begin
            w.data = {$urandom, $urandom};
            w.sop  = (k == 0);
            w.eop  = (k == nw - 1);
            w.mod  = w.eop ? 3'(n % 8) : 3'd0;
            w.err  = w.eop && merr;
            mac_q.push_back(w);
            w.err  = w.eop && ferr;
            exp_q.push_back(w);
        end
        exp_frames++;
        if (ferr) exp_errs++;
        snap_q.push_back('{f: 32'(exp_frames), e: 32'(exp_errs),
                           l: 16'(n)});
        pend_sop_err = 0;
    endtask

    // Frame cut short: sop and a few body words, never an eop.
    task automatic add_partial(input int nw);
        pkt_word_t w;
        for (int k = 0; k < nw; k++) begin
            w.data = {$urandom, $urandom};
            w.sop  = (k == 0);
            w.eop  = 1'b0;
            w.mod  = 3'd0;
            w.err  = 1'b0;
            mac_q.push_back(w);
            exp_q.push_back(w);
        end
        exp_errs++;
        pend_sop_err = 0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0 ||
                snap_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_drain_in_time"}, 64'(t < 5000), 64'd1);
        repeat (3) @(posedge clk);
        #3;
    endtask

    task automatic model_clear();
        mac_q.delete();
        exp_q.delete();
        snap_q.delete();
        exp_frames = 0;
        exp_errs = 0;
        pend_sop_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // MAC rx FIFO: returns the next queued word one cycle after ren.
    initial begin
        bit ren_s;
        pkt_word_t w;
        val = 0; sop = 0; eop = 0; data = '0; mod = '0; err = 0;
        avail = 0; out_ready = 0;
        forever begin
            @(negedge clk);
            ren_s = ren;
            @(posedge clk);
            #1;
            if (ren_s) chk("ren_has_word", 64'(mac_q.size() > 0), 64'd1);
            if (ren_s && mac_q.size() > 0) begin
                w = mac_q.pop_front();
                val = 1; data = w.data; sop = w.sop; eop = w.eop;
                mod = w.mod; err = w.err;
            end else if (inject) begin
                val = 1; data = {$urandom, $urandom}; sop = 0; eop = 0;
                mod = 0; err = 0;
                inject = 0;
            end else begin
                val = 0; data = '0; sop = 0; eop = 0; mod = 0; err = 0;
            end
            avail = (mac_q.size() > 0);
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0)
                                   : force_ready;
        end
    end

    // Scoreboard: every popped word and every frame_done pulse.
    initial begin
        pkt_word_t e;
        snap_t s;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("ren_on_eop", 64'(ren && val && eop), 64'd0);
                if (meas && ren) begin
                    if (ren_cnt == 0) ren_first = cyc;
                    ren_last = cyc;
                    ren_cnt++;
                end
                if (out_valid && out_ready) begin
                    out_cnt++;
                    chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_sop", 64'(out_sop), 64'(e.sop));
                        chk("out_eop", 64'(out_eop), 64'(e.eop));
                        chk("out_mod", 64'(out_mod), 64'(e.mod));
                        chk("out_err", 64'(out_err), 64'(e.err));
                    end
                end
                if (frame_done) begin
                    chk("done_expected", 64'(snap_q.size() > 0), 64'd1);
                    if (snap_q.size() > 0) begin
                        s = snap_q.pop_front();
                        chk("frame_cnt", 64'(frame_cnt), 64'(s.f));
                        chk("err_cnt", 64'(err_cnt), 64'(s.e));
                        chk("last_len", 64'(last_len), 64'(s.l));
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ren"}, 64'(ren), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_side"},
            64'({out_sop, out_eop, out_mod, out_err}), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_last_len"}, 64'(last_len), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int t;
        int o0;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        // 64-byte frame, ready held high.
        meas = 1; ren_cnt = 0; o0 = out_cnt;
        add_frame(64, 0);
        wait_drain("f64");
        meas = 0;
        chk("f64_words", 64'(out_cnt - o0), 64'd8);
        chk("f64_ren_cnt", 64'(ren_cnt), 64'd8);
        chk("f64_ren_span", 64'(ren_last - ren_first + 1), 64'd8);
        chk("f64_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("f64_last_len", 64'(last_len), 64'd64);
        chk("f64_err_cnt", 64'(err_cnt), 64'd0);

        // 65-byte frame with the sink stalled.
        force_ready = 0;
        @(posedge clk);
        #3;
        meas = 1; ren_cnt = 0;
        add_frame(65, 0);
        repeat (12) @(posedge clk);
        #3;
        chk("stall_ren_cnt", 64'(ren_cnt), 64'd2);
        force_ready = 1;
        wait_drain("f65");
        meas = 0;
        chk("f65_last_len", 64'(last_len), 64'd65);
        chk("f65_frame_cnt", 64'(frame_cnt), 64'd2);

        // Runt then giant.
        do_reset();
        add_frame(60, 0);
        add_frame(1600, 0);
        wait_drain("runt_giant");
        chk("rg_err_cnt", 64'(err_cnt), 64'd2);
        chk("rg_frame_cnt", 64'(frame_cnt), 64'd2);

        // Stray word right after reset, then a good 64-byte frame.
        do_reset();
        inject = 1;
        pend_sop_err = 1;
        repeat (2) @(posedge clk);
        #3;
        add_frame(64, 0);
        wait_drain("stray");
        chk("stray_err_cnt", 64'(err_cnt), 64'd1);
        chk("stray_frame_cnt", 64'(frame_cnt), 64'd1);

        // Reset in the middle of a 16-word frame.
        add_frame(128, 0);
        t = 0;
        while (mac_q.size() > 12 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #3;
        chk("midreset_reached", 64'(t < 200), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        model_clear();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        add_frame(128, 0);
        wait_drain("post_reset");
        chk("pr_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("pr_err_cnt", 64'(err_cnt), 64'd0);
        chk("pr_last_len", 64'(last_len), 64'd128);

        // Back-to-back frames with avail held high.
        do_reset();
        @(posedge clk);
        #3;
        meas = 1; ren_cnt = 0;
        add_frame(64, 0);
        add_frame(64, 0);
        wait_drain("b2b");
        meas = 0;
        chk("b2b_ren_cnt", 64'(ren_cnt), 64'd16);
        chk("b2b_ren_span", 64'(ren_last - ren_first + 1), 64'd17);
        chk("b2b_frame_cnt", 64'(frame_cnt), 64'd2);

        // Frame aborted by a new sop.
        add_partial(3);
        add_frame(100, 0);
        wait_drain("abort");
        chk("abort_frame_cnt", 64'(frame_cnt), 64'd3);
        chk("abort_err_cnt", 64'(err_cnt), 64'd1);

        // Randomized traffic with random backpressure.
        rand_ready = 1;
        add_frame(5, 1);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0:       n = $urandom_range(1, 63);
                1:       n = $urandom_range(1500, 1600);
                default: n = $urandom_range(64, 300);
            endcase
            if ($urandom_range(0, 5) == 0) begin
                wait_drain("rnd_gap");
                inject = 1;
                pend_sop_err = 1;
                repeat (2) @(posedge clk);
                #3;
            end
            add_frame(n, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) wait_drain("rnd");
        end
        wait_drain("rnd_end");
        chk("rnd_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("rnd_err_cnt", 64'(err_cnt), 64'(exp_errs));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
